// File: rtl/ps2_pkg.sv
// ps2_pkg: scancode constants, control-byte list and the key event type shared by the PS/2 decoder.
package ps2_pkg;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {IDLE, PFX_E0, PFX_F0, PFX_E0F0} ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [7:0] ascii;
    } key_event_t;

    // Keyboard status/ack bytes that never form part of a key sequence.
    function automatic logic is_ctrl(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction
endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// ps2_key_event_decoder_if: scancode input strobe and key event valid/ready output bundle.
interface ps2_key_event_decoder_if;
    logic       sc_valid;
    logic [7:0] sc_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_repeat;
    logic [7:0] ev_ascii;

    modport master (
        output sc_valid, sc_data, ev_ready,
        input  ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii
    );
    modport slave (
        input  sc_valid, sc_data, ev_ready,
        output ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii
    );
endinterface

// File: rtl/ps2_ascii_map.sv
// ps2_ascii_map: set-2 scancode to ASCII, applying Shift to symbols and Shift^CapsLock to letters.
module ps2_ascii_map
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);
    // {is_letter, unshifted, shifted}
    logic [16:0] t;

    always_comb begin
        t = '0;
        case (code)
            8'h1C: t = {1'b1, "a", "A"};
            8'h32: t = {1'b1, "b", "B"};
            8'h21: t = {1'b1, "c", "C"};
            8'h23: t = {1'b1, "d", "D"};
            8'h24: t = {1'b1, "e", "E"};
            8'h2B: t = {1'b1, "f", "F"};
            8'h34: t = {1'b1, "g", "G"};
            8'h33: t = {1'b1, "h", "H"};
            8'h43: t = {1'b1, "i", "I"};
            8'h3B: t = {1'b1, "j", "J"};
            8'h42: t = {1'b1, "k", "K"};
            8'h4B: t = {1'b1, "l", "L"};
            8'h3A: t = {1'b1, "m", "M"};
            8'h31: t = {1'b1, "n", "N"};
            8'h44: t = {1'b1, "o", "O"};
            8'h4D: t = {1'b1, "p", "P"};
            8'h15: t = {1'b1, "q", "Q"};
            8'h2D: t = {1'b1, "r", "R"};
            8'h1B: t = {1'b1, "s", "S"};
            8'h2C: t = {1'b1, "t", "T"};
            8'h3C: t = {1'b1, "u", "U"};
            8'h2A: t = {1'b1, "v", "V"};
            8'h1D: t = {1'b1, "w", "W"};
            8'h22: t = {1'b1, "x", "X"};
            8'h35: t = {1'b1, "y", "Y"};
            8'h1A: t = {1'b1, "z", "Z"};
            8'h16: t = {1'b0, "1", "!"};
            8'h1E: t = {1'b0, "2", "@"};
            8'h26: t = {1'b0, "3", "#"};
            8'h25: t = {1'b0, "4", "$"};
            8'h2E: t = {1'b0, "5", "%"};
            8'h36: t = {1'b0, "6", "^"};
            8'h3D: t = {1'b0, "7", "&"};
            8'h3E: t = {1'b0, "8", "*"};
            8'h46: t = {1'b0, "9", "("};
            8'h45: t = {1'b0, "0", ")"};
            8'h0E: t = {1'b0, 8'h60, 8'h7E};
            8'h4E: t = {1'b0, "-", "_"};
            8'h55: t = {1'b0, "=", "+"};
            8'h54: t = {1'b0, "[", "{"};
            8'h5B: t = {1'b0, "]", "}"};
            8'h5D: t = {1'b0, 8'h5C, 8'h7C};
            8'h4C: t = {1'b0, ";", ":"};
            8'h52: t = {1'b0, 8'h27, 8'h22};
            8'h41: t = {1'b0, ",", "<"};
            8'h49: t = {1'b0, ".", ">"};
            8'h4A: t = {1'b0, "/", "?"};
            8'h29: t = {1'b0, 8'h20, 8'h20};
            8'h5A: t = {1'b0, 8'h0D, 8'h0D};
            8'h66: t = {1'b0, 8'h08, 8'h08};
            default: t = '0;
        endcase
    end

    assign ascii = (t[16] ? (shift ^ caps) : shift) ? t[7:0] : t[15:8];
endmodule

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: turns the PS/2 set-2 byte stream into key events with ASCII,
// tracking Shift/CapsLock and typematic repeats, queued in a first-word-fall-through FIFO.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ps2_key_event_decoder_if.slave bus,
    output logic                  shift,
    output logic                  caps,
    output logic [CNT_W-1:0]      press_cnt,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    ps2_state_t state, state_n;
    logic [7:0] b, map_ascii, held_code;
    logic       held_ext, held_v, held_hit;
    logic       ctl, is_pfx, emit, press, e_ext, e_brk, rpt, is_shift_key;
    key_event_t ev, head;
    key_event_t mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic       full, push, pop;

    assign b      = bus.sc_data;
    assign ctl    = is_ctrl(b);
    assign is_pfx = (b == SC_EXT) || (b == SC_BRK);
    // Every non-control, non-prefix byte terminates a sequence and produces an event.
    assign emit   = bus.sc_valid && !ctl && !is_pfx;
    assign e_ext  = state inside {PFX_E0, PFX_E0F0};
    assign e_brk  = state inside {PFX_F0, PFX_E0F0};
    assign press  = emit && !e_brk;

    always_comb begin
        state_n = state;
        if (bus.sc_valid)
            state_n = (b == SC_EXT && state inside {IDLE, PFX_E0}) ? PFX_E0 :
                      (b == SC_BRK && state == IDLE)               ? PFX_F0 :
                      (b == SC_BRK && state == PFX_E0)             ? PFX_E0F0 : IDLE;
    end

    assign held_hit     = held_v && held_code == b && held_ext == e_ext;
    assign rpt          = !e_brk && held_hit;
    assign is_shift_key = !e_ext && (b == SC_LSHIFT || b == SC_RSHIFT);

    ps2_ascii_map u_map (
        .code  (b),
        .shift (shift),
        .caps  (caps),
        .ascii (map_ascii)
    );

    assign ev = '{code: b, ext: e_ext, brk: e_brk, rpt: rpt,
                  ascii: (e_brk || e_ext) ? 8'h00 : map_ascii};

    assign full = count == CW'(FIFO_DEPTH);
    assign pop  = bus.ev_valid && bus.ev_ready;
    assign push = emit && (!full || pop);
    assign head = mem[rd_ptr];

    assign bus.ev_valid = count != '0;
    assign {bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_repeat, bus.ev_ascii} =
        bus.ev_valid ? head : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held_code <= '0;
            held_ext  <= 1'b0;
            held_v    <= 1'b0;
            shift     <= 1'b0;
            caps      <= 1'b0;
            press_cnt <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_n;
            if (press && !rpt) begin
                held_code <= b;
                held_ext  <= e_ext;
                held_v    <= 1'b1;
                press_cnt <= press_cnt + CNT_W'(1);
            end
            if (emit && e_brk && held_hit)
                held_v <= 1'b0;
            if (press && is_shift_key)
                shift <= 1'b1;
            else if (emit && e_brk && is_shift_key)
                shift <= 1'b0;
            if (press && !rpt && !e_ext && b == SC_CAPS)
                caps <= !caps;
            if (emit && !push)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ev;
    end
endmodule
